// File: rtl/hms_clock_core_pkg.sv
// hms_clock_core shared types and constants.
// Mode/position encodings, field width, limits.
package hms_clock_core_pkg;

  localparam int FIELD_W = 6;
  localparam logic [FIELD_W-1:0] SEC_MAX = 6'd59;
  localparam logic [FIELD_W-1:0] MIN_MAX = 6'd59;

  typedef enum logic {
    MODE_CLOCK = 1'b0,
    MODE_SETUP = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    POS_SEC  = 2'd0,
    POS_MIN  = 2'd1,
    POS_HOUR = 2'd2
  } pos_e;

  function automatic pos_e pos_next(pos_e p);
    pos_e n;
    n = POS_SEC;
    unique case (1'b1)
      (p == POS_SEC): n = POS_MIN;
      (p == POS_MIN): n = POS_HOUR;
      default:        n = POS_SEC;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mod_ud_cnt.sv
// Wrapping up/down field counter 0..i_max.
// Ports: clk, rst_n, i_max, i_inc, i_dec, i_clr, o_cnt, o_carry.
import hms_clock_core_pkg::*;

module mod_ud_cnt (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FIELD_W-1:0] i_max,
  input  logic               i_inc,
  input  logic               i_dec,
  input  logic               i_clr,
  output logic [FIELD_W-1:0] o_cnt,
  output logic               o_carry
);

  logic up;
  logic dn;
  logic at_max;

  assign up      = i_inc & ~i_dec;
  assign dn      = i_dec & ~i_inc;
  assign at_max  = (o_cnt == i_max);
  assign o_carry = up & at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cnt <= '0;
    end else if (i_clr) begin
      o_cnt <= '0;
    end else if (up) begin
      o_cnt <= at_max ? '0 : o_cnt + FIELD_W'(1);
    end else if (dn) begin
      o_cnt <= (o_cnt == '0) ? i_max
                             : o_cnt - FIELD_W'(1);
    end
  end

endmodule

// File: rtl/hms_clock_core.sv
// hour:min:sec core with prescaler, CLOCK/SETUP mode.
// Ports: clk, rst_n, pulses in; fields, mode, pos, strobes out.
import hms_clock_core_pkg::*;

module hms_clock_core #(
  parameter int unsigned CLK_DIV  = 50_000_000,
  parameter int unsigned HOUR_MAX = 23
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_mode_pls,
  input  logic               i_pos_pls,
  input  logic               i_inc_pls,
  input  logic               i_dec_pls,
  output logic [FIELD_W-1:0] o_sec,
  output logic [FIELD_W-1:0] o_min,
  output logic [FIELD_W-1:0] o_hour,
  output logic               o_mode,
  output logic [1:0]         o_pos,
  output logic               o_tick,
  output logic               o_day_hit,
  output logic               o_blink
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] DIV_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] DIV_HALF = PW'(CLK_DIV / 2);
  localparam logic [FIELD_W-1:0] H_MAX = FIELD_W'(HOUR_MAX);

  mode_e         mode;
  pos_e          pos;
  logic [PW-1:0] pre;

  logic tick_en;
  logic set_ok;
  logic set_inc;
  logic set_dec;
  logic sec_set;
  logic enter_clk;
  logic sec_inc, sec_dec, sec_cy;
  logic min_inc, min_dec, min_cy;
  logic hr_inc, hr_dec, hr_cy;

  assign tick_en = (mode == MODE_CLOCK) && (pre == DIV_LAST);
  assign enter_clk = (mode == MODE_SETUP) && i_mode_pls;

  // a mode pulse in the same cycle swallows inc/dec
  assign set_ok  = (mode == MODE_SETUP) && !i_mode_pls;
  assign set_inc = set_ok & i_inc_pls;
  assign set_dec = set_ok & i_dec_pls;

  // restart the second when seconds are edited
  assign sec_set = set_ok && (pos == POS_SEC)
                   && (i_inc_pls ^ i_dec_pls);

  assign sec_inc = tick_en
                 | (set_inc & (pos == POS_SEC));
  assign sec_dec = set_dec & (pos == POS_SEC);
  // carries only chain while counting time
  assign min_inc = (tick_en & sec_cy)
                 | (set_inc & (pos == POS_MIN));
  assign min_dec = set_dec & (pos == POS_MIN);
  assign hr_inc  = (tick_en & min_cy)
                 | (set_inc & (pos == POS_HOUR));
  assign hr_dec  = set_dec & (pos == POS_HOUR);

  mod_ud_cnt u_sec (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_max  (SEC_MAX),
    .i_inc  (sec_inc),
    .i_dec  (sec_dec),
    .i_clr  (1'b0),
    .o_cnt  (o_sec),
    .o_carry(sec_cy)
  );

  mod_ud_cnt u_min (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_max  (MIN_MAX),
    .i_inc  (min_inc),
    .i_dec  (min_dec),
    .i_clr  (1'b0),
    .o_cnt  (o_min),
    .o_carry(min_cy)
  );

  mod_ud_cnt u_hour (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_max  (H_MAX),
    .i_inc  (hr_inc),
    .i_dec  (hr_dec),
    .i_clr  (1'b0),
    .o_cnt  (o_hour),
    .o_carry(hr_cy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (enter_clk || sec_set) begin
      pre <= '0;
    end else if (pre == DIV_LAST) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_tick    <= 1'b0;
      o_day_hit <= 1'b0;
      o_blink   <= 1'b0;
    end else begin
      o_tick    <= tick_en;
      o_day_hit <= tick_en & hr_cy;
      o_blink   <= (pre >= DIV_HALF);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= MODE_CLOCK;
      pos  <= POS_SEC;
    end else if (i_mode_pls) begin
      if (mode == MODE_CLOCK) begin
        mode <= MODE_SETUP;
        pos  <= POS_SEC;
      end else begin
        mode <= MODE_CLOCK;
      end
    end else if (mode == MODE_SETUP && i_pos_pls) begin
      pos <= pos_next(pos);
    end
  end

  assign o_mode = mode;
  assign o_pos  = pos;

endmodule
